// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, op-class decode and FSM state
// for the RV64 M-extension multiply/divide unit
package mdu_pkg;

  localparam logic [3:0] OP_MUL    = 4'b0000;
  localparam logic [3:0] OP_MULH   = 4'b0001;
  localparam logic [3:0] OP_MULHSU = 4'b0010;
  localparam logic [3:0] OP_MULHU  = 4'b0011;
  localparam logic [3:0] OP_DIV    = 4'b0100;
  localparam logic [3:0] OP_DIVU   = 4'b0101;
  localparam logic [3:0] OP_REM    = 4'b0110;
  localparam logic [3:0] OP_REMU   = 4'b0111;
  localparam logic [3:0] OP_MULW   = 4'b1000;
  localparam logic [3:0] OP_DIVW   = 4'b1100;
  localparam logic [3:0] OP_DIVUW  = 4'b1101;
  localparam logic [3:0] OP_REMW   = 4'b1110;
  localparam logic [3:0] OP_REMUW  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef struct packed {
    logic ill;
    logic mul;
    logic word;
    logic hi;
    logic rem;
    logic dz;
    logic ovf;
    logic sa;
    logic sb;
  } ctl_t;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    return !(op[3] && !op[2] && op[1:0] != 2'b00);
  endfunction

  function automatic logic is_mul(
    input logic [3:0] op
  );
    return !op[2];
  endfunction

  function automatic logic is_div(
    input logic [3:0] op
  );
    return op[2] && !op[1];
  endfunction

  function automatic logic is_rem(
    input logic [3:0] op
  );
    return op[2] && op[1];
  endfunction

  function automatic logic is_word(
    input logic [3:0] op
  );
    return op[3];
  endfunction

  function automatic logic is_signed_op1(
    input logic [3:0] op
  );
    if (op[2]) return !op[0];
    return !op[3] && (op[1] ^ op[0]);
  endfunction

  function automatic logic is_signed_op2(
    input logic [3:0] op
  );
    if (op[2]) return !op[0];
    return op == OP_MULH;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/response handshake bundle
// master = issuing stage, slave = mdu
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
);

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op_type;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rst;
  logic            busy;

  modport master (
    output in_valid,
    output op_type,
    output op1,
    output op2,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  rst,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  op_type,
    input  op1,
    input  op2,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output rst,
    output busy
  );

endinterface

// File: rtl/mdu_div_core.sv
// mdu_div_core: restoring divider on magnitudes
// one quotient bit per step, quotient shifts in at LSB
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dvd_i,
  input  logic [XLEN-1:0] dsr_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN:0]   part;
  logic [XLEN:0]   diff;

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    part  = {rem_q, quo_q[XLEN-1]};
    diff  = part - {1'b0, dsr_q};
    if (load) begin
      quo_d = dvd_i;
      rem_d = '0;
      dsr_d = dsr_i;
    end else if (step) begin
      quo_d = {quo_q[XLEN-2:0], !diff[XLEN]};
      rem_d = diff[XLEN] ? part[XLEN-1:0]
                         : diff[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
    end
  end

  assign quo_o = quo_q;
  assign rem_o = rem_q;

endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle RV64 M-extension multiply/divide unit
// MDU_FAST_MUL_EN: single-cycle multiply instead of shift-add
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input logic  clk,
  input logic  rst_n,
  mdu_if.slave io
);

  localparam int PW = 2 * XLEN;
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MINV =
    {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sx(
    input logic [31:0] v
  );
    return XLEN'($signed(v));
  endfunction

  state_e          state_q, state_d;
  ctl_t            ctl_q, ctl_d, ctl_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] mpl_q, mpl_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcd_q, mcd_d;
  logic            vld_q, vld_d;

  logic            take, s1, s2, zk;
  logic [CNT_W-1:0] k1;
  logic [XLEN-1:0] ea, eb, ma, mb, dvd;
  logic [XLEN-1:0] dq, dr, q_fix, r_fix;
  logic [XLEN-1:0] dvd_w, fix;
  logic [PW-1:0]   prod;
  logic            dv_load, dv_step;

  assign take = io.in_valid && state_q == IDLE
             && !io.flush;

  // request decode: effective operands, magnitudes, K
  always_comb begin
    ctl_n = '0;
    s1 = is_signed_op1(io.op_type);
    s2 = is_signed_op2(io.op_type);
    ctl_n.word = is_word(io.op_type);
    ctl_n.ill = !op_legal(io.op_type)
             || (XLEN != 64 && ctl_n.word);
    ea = io.op1;
    eb = io.op2;
    if (ctl_n.word) begin
      ea = s1 ? sx(io.op1[31:0])
              : XLEN'(io.op1[31:0]);
      eb = s2 ? sx(io.op2[31:0])
              : XLEN'(io.op2[31:0]);
    end
    ma = (s1 && ea[XLEN-1]) ? -ea : ea;
    mb = (s2 && eb[XLEN-1]) ? -eb : eb;
    dvd = ctl_n.word ? ma << 32 : ma;
    if (!ctl_n.ill) begin
      ctl_n.mul = is_mul(io.op_type);
      ctl_n.hi  = io.op_type[1:0] != 2'b00;
      ctl_n.rem = is_rem(io.op_type);
      ctl_n.sa  = s1 && ea[XLEN-1];
      ctl_n.sb  = s2 && eb[XLEN-1];
      if (!ctl_n.mul) begin
        ctl_n.dz  = eb == '0;
        ctl_n.ovf = s1 && (ctl_n.word
          ? (io.op1[31:0] == 32'h8000_0000
             && io.op2[31:0] == 32'hFFFF_FFFF)
          : (io.op1 == MINV && io.op2 == ONES));
      end
    end
`ifdef MDU_FAST_MUL_EN
    zk = ctl_n.ill || ctl_n.mul
      || ctl_n.dz || ctl_n.ovf;
`else
    zk = ctl_n.ill || ctl_n.dz || ctl_n.ovf;
`endif
    k1 = ctl_n.word ? CNT_W'(31)
                    : CNT_W'(XLEN - 1);
  end

  // sign fix-up and result select on DONE entry
  always_comb begin
    prod  = (ctl_q.sa ^ ctl_q.sb) ? -acc_q : acc_q;
    q_fix = (ctl_q.sa ^ ctl_q.sb) ? -dq : dq;
    r_fix = ctl_q.sa ? -dr : dr;
    dvd_w = ctl_q.word ? sx(a_q[31:0]) : a_q;
    fix   = ONES;
    if (!ctl_q.ill) begin
      unique case (1'b1)
        ctl_q.mul && ctl_q.word:
          fix = sx(acc_q[31:0]);
        ctl_q.mul && !ctl_q.word && !ctl_q.hi:
          fix = prod[XLEN-1:0];
        ctl_q.mul && !ctl_q.word && ctl_q.hi:
          fix = prod[PW-1:XLEN];
        !ctl_q.mul && ctl_q.dz:
          fix = ctl_q.rem ? dvd_w : ONES;
        !ctl_q.mul && ctl_q.ovf:
          fix = ctl_q.rem ? '0 : dvd_w;
        !ctl_q.mul && !ctl_q.dz
          && !ctl_q.ovf && ctl_q.rem:
          fix = ctl_q.word ? sx(r_fix[31:0])
                           : r_fix;
        default:
          fix = ctl_q.word ? sx(q_fix[31:0])
                           : q_fix;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    acc_d   = acc_q;
    mcd_d   = mcd_q;
    mpl_d   = mpl_q;
    res_d   = res_q;
    vld_d   = vld_q;
    dv_load = 1'b0;
    dv_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          ctl_d   = ctl_n;
          cnt_d   = k1;
          a_d     = io.op1;
          mcd_d   = PW'(ma);
          mpl_d   = mb;
`ifdef MDU_FAST_MUL_EN
          acc_d   = PW'(ma) * PW'(mb);
`else
          acc_d   = '0;
`endif
          dv_load = !ctl_n.mul;
          state_d = zk ? DONE : CALC;
        end
      end
      CALC: begin
        if (ctl_q.mul) begin
          if (mpl_q[0]) acc_d = acc_q + mcd_q;
          mcd_d = mcd_q << 1;
          mpl_d = mpl_q >> 1;
        end else begin
          dv_step = 1'b1;
        end
        if (cnt_q == '0) state_d = DONE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      DONE: begin
        if (!vld_q) begin
          res_d = fix;
          vld_d = 1'b1;
        end else if (io.out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (io.flush) begin
      state_d = IDLE;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctl_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      mcd_q   <= '0;
      mpl_q   <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      mcd_q   <= mcd_d;
      mpl_q   <= mpl_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

  mdu_div_core #(
    .XLEN(XLEN)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (dv_load),
    .step  (dv_step),
    .dvd_i (dvd),
    .dsr_i (mb),
    .quo_o (dq),
    .rem_o (dr)
  );

  assign io.in_ready  = state_q == IDLE;
  assign io.busy      = state_q != IDLE;
  assign io.out_valid = vld_q;
  assign io.rst       = res_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed scoreboard bench for mdu
// expected results queued at accept, popped at out_valid
module tb_mdu;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int ML  = 1;
  localparam int MLW = 1;
`else
  localparam int ML  = 65;
  localparam int MLW = 33;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];

  mdu_if #(.XLEN(64)) io();

  mdu #(
    .XLEN  (64),
    .CNT_W (7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag,
                       input logic [3:0] op,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       input logic [63:0] e,
                       input int lat,
                       input int hold);
    int n;
    int el;
    logic [63:0] ee;
    @(negedge clk);
    chk({tag, ".rdy"}, 64'(io.in_ready), 64'd1);
    io.in_valid = 1'b1;
    io.op_type  = op;
    io.op1      = a;
    io.op2      = b;
    @(posedge clk);
    exp_q.push_back(e);
    lat_q.push_back(lat);
    #1;
    io.in_valid = 1'b0;
    io.op_type  = ~op;
    io.op1      = ~a;
    io.op2      = ~b;
    n = 0;
    while (!io.out_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    el = lat_q.pop_front();
    chk({tag, ".lat"}, 64'(n), 64'(el));
    chk({tag, ".irdy"}, 64'(io.in_ready), 64'd0);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    ee = exp_q.pop_front();
    if (hold > 0)
      chk({tag, ".hold"}, 64'(io.out_valid), 64'd1);
    chk({tag, ".res"}, io.rst, ee);
    io.out_ready = 1'b1;
    io.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    io.in_valid  = 1'b0;
    chk({tag, ".ovl0"}, 64'(io.out_valid), 64'd0);
    chk({tag, ".noacc"}, 64'(io.busy), 64'd0);
  endtask

  initial begin
    int n;
    logic [63:0] a, b;
    io.in_valid  = 1'b0;
    io.op_type   = '0;
    io.op1       = '0;
    io.op2       = '0;
    io.flush     = 1'b0;
    io.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.ovl", 64'(io.out_valid), 64'd0);
    chk("rst.busy", 64'(io.busy), 64'd0);
    chk("rst.res", io.rst, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.rdy", 64'(io.in_ready), 64'd1);

    do_op("mul", OP_MUL, 64'd7, -64'sd3,
          64'hFFFF_FFFF_FFFF_FFEB, ML, 10);
    do_op("mulhu", OP_MULHU, '1, '1,
          64'hFFFF_FFFF_FFFF_FFFE, ML, 0);
    do_op("mulhsu", OP_MULHSU, '1, 64'd2,
          '1, ML, 0);
    do_op("mulh_p", OP_MULH, 64'h4000_0000_0000_0000,
          64'd4, 64'd1, ML, 0);
    do_op("mulh_n", OP_MULH, -64'sd2, 64'd3,
          '1, ML, 0);
    do_op("mulw", OP_MULW, 64'h1_0000_0003,
          64'hFFFF_FFFF_8000_0000,
          64'hFFFF_FFFF_8000_0000, MLW, 0);
    do_op("div", OP_DIV, -64'sd7, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    do_op("rem", OP_REM, -64'sd7, 64'd2,
          '1, 65, 0);
    do_op("divu0", OP_DIVU, 64'd100, 64'd0,
          '1, 1, 0);
    do_op("remu0", OP_REMU, 64'd100, 64'd0,
          64'd100, 1, 0);
    do_op("divov", OP_DIV, 64'h8000_0000_0000_0000,
          '1, 64'h8000_0000_0000_0000, 1, 0);
    do_op("remov", OP_REM, 64'h8000_0000_0000_0000,
          '1, 64'd0, 1, 0);
    do_op("divwov", OP_DIVW, 64'h0000_0000_8000_0000,
          64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    do_op("divuw", OP_DIVUW, 64'hFFFF_FFFF, 64'd1,
          '1, 33, 0);
    do_op("remw", OP_REMW, 64'h1234_5678_FFFF_FFF9,
          64'd3, '1, 33, 0);
    do_op("divw", OP_DIVW, 64'h1234_5678_FFFF_FFF9,
          64'hABCD_0000_0000_0003,
          64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
    do_op("remuw0", OP_REMUW, 64'h5555_0000_8000_0000,
          64'hFFFF_0000_0000_0000,
          64'hFFFF_FFFF_8000_0000, 1, 0);
    do_op("divu", OP_DIVU, '1, 64'h10,
          64'h0FFF_FFFF_FFFF_FFFF, 65, 0);
    do_op("ill", 4'b1010, 64'd5, 64'd6,
          '1, 1, 0);

    for (int i = 0; i < 3; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      do_op("rmul", OP_MUL, a, b, a * b, ML, 0);
      b = {32'd0, $urandom} | 64'd1;
      do_op("rdivu", OP_DIVU, a, b, a / b, 65, 0);
      do_op("rremu", OP_REMU, a, b, a % b, 65, 0);
      b = 64'($urandom_range(2, 5000));
      if (i == 1) b = -b;
      do_op("rdiv", OP_DIV, a, b,
            64'($signed(a) / $signed(b)), 65, 0);
    end

    @(negedge clk);
    io.in_valid = 1'b1;
    io.op_type  = OP_DIV;
    io.op1      = 64'd1000;
    io.op2      = 64'd7;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    io.flush    = 1'b1;
    io.in_valid = 1'b1;
    io.op_type  = OP_DIVU;
    @(posedge clk);
    #1;
    chk("fl.busy", 64'(io.busy), 64'd0);
    chk("fl.ovl", 64'(io.out_valid), 64'd0);
    chk("fl.rdy", 64'(io.in_ready), 64'd1);
    io.flush    = 1'b0;
    io.in_valid = 1'b0;
    n = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (io.out_valid) n++;
    end
    chk("fl.noout", 64'(n), 64'd0);
    do_op("fl.after", OP_DIVU, 64'd20, 64'd3,
          64'd6, 65, 0);

    @(negedge clk);
    io.in_valid = 1'b1;
    io.op_type  = OP_MUL;
    io.op1      = 64'd3;
    io.op2      = 64'd3;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst.ovl", 64'(io.out_valid), 64'd0);
    chk("mrst.busy", 64'(io.busy), 64'd0);
    chk("mrst.res", io.rst, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst.rdy", 64'(io.in_ready), 64'd1);
    n = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (io.out_valid) n++;
    end
    chk("mrst.noout", 64'(n), 64'd0);
    do_op("mrst.after", OP_MUL, 64'd6, 64'd7,
          64'd42, ML, 0);

    chk("sb.empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
